// File: rtl/kme_unpack_pkg.sv
// Shared state type and sizing/slice helpers for the KME FIFO unpacker.
package kme_unpack_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } unpack_state_e;

  function automatic int unsigned num_words(input int unsigned in_width,
                                            input int unsigned out_width);
    return in_width / out_width;
  endfunction

  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 2) ? $clog2(words) : 1;
  endfunction

  // Maps the emission index onto the physical slice number of the entry.
  function automatic int unsigned slice_sel(input int unsigned idx,
                                            input int unsigned words,
                                            input bit          msw_first);
    return msw_first ? (words - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/kme_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module kme_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/kme_fifo_unpacker.sv
// Pops wide KME FIFO entries and serialises them into OUT_WIDTH words under stall.
// Optional parity outputs are enabled by defining KME_FIFO_UNPACKER_PARITY_EN.
module kme_fifo_unpacker
  import kme_unpack_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 96,
  parameter int unsigned OUT_WIDTH = 32,
  parameter bit          MSW_FIRST = 1'b0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  fifo_out,
  input  logic                 fifo_out_valid,
  output logic                 fifo_out_ack,
  output logic [OUT_WIDTH-1:0] word_out,
  output logic                 word_valid,
  output logic                 word_first,
  output logic                 word_last,
  input  logic                 word_stall,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] entry_cnt
`ifdef KME_FIFO_UNPACKER_PARITY_EN
  ,
  output logic                 word_par,
  output logic [7:0]           par_err_cnt
`endif
);

  localparam int unsigned NUM_WORDS = num_words(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned IDX_W     = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  if ((OUT_WIDTH == 0) || (IN_WIDTH < OUT_WIDTH) || ((IN_WIDTH % OUT_WIDTH) != 0))
  begin : g_width_check
    $error("IN_WIDTH must be a non-zero integer multiple of OUT_WIDTH");
  end

  unpack_state_e        state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IN_WIDTH-1:0]  hold_q, hold_d;
  logic                 accept;
  logic                 is_last;
  logic [IDX_W-1:0]     sel;
  logic [OUT_WIDTH-1:0] slices [NUM_WORDS];

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_slice
    assign slices[i] = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    busy         = (state_q == StSend);
    word_valid   = busy;
    accept       = word_valid & ~word_stall;
    is_last      = (idx_q == LAST_IDX);
    fifo_out_ack = fifo_out_valid & ~rst & ((state_q == StIdle) | (accept & is_last));
    sel          = IDX_W'(slice_sel(32'(idx_q), NUM_WORDS, MSW_FIRST));
    word_out     = busy ? slices[sel] : '0;
    word_first   = word_valid & (idx_q == '0);
    word_last    = word_valid & is_last;

    unique case (state_q)
      StIdle: begin
        if (fifo_out_valid) begin
          hold_d  = fifo_out;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (accept) begin
          if (!is_last) begin
            idx_d = idx_q + 1'b1;
          end else if (fifo_out_valid) begin
            // Back-to-back reload keeps the output stream bubble-free.
            hold_d = fifo_out;
            idx_d  = '0;
          end else begin
            idx_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  kme_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_entry_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (accept & is_last),
    .cnt (entry_cnt)
  );

`ifdef KME_FIFO_UNPACKER_PARITY_EN
  assign word_par = ^word_out;

  // Bit 0 of the top slice is a debug parity-inject marker.
  kme_sat_counter #(
    .WIDTH (8)
  ) u_par_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (accept & hold_q[IN_WIDTH-OUT_WIDTH]),
    .cnt (par_err_cnt)
  );
`endif

endmodule

// File: tb/tb_kme_fifo_unpacker.sv
// Directed scoreboard bench: LSW-first and MSW-first instances share one FIFO model.
module tb_kme_fifo_unpacker;

  localparam int unsigned IW = 96;
  localparam int unsigned OW = 32;
  localparam int unsigned NW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] fifo_out;
  logic          fifo_out_valid;
  logic          word_stall;

  logic          ack_a, ack_b;
  logic [OW-1:0] word_a, word_b;
  logic          valid_a, valid_b, first_a, first_b, last_a, last_b, busy_a, busy_b;
  logic [15:0]   cnt_a;
  logic [1:0]    cnt_b;
`ifdef KME_FIFO_UNPACKER_PARITY_EN
  logic          par_a, par_b;
  logic [7:0]    perr_a, perr_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [IW-1:0] fifo_q [$];
  logic [OW-1:0] exp_a [$];
  logic [OW-1:0] exp_b [$];

  always #5 clk = ~clk;

  kme_fifo_unpacker #(
    .IN_WIDTH (IW), .OUT_WIDTH (OW), .MSW_FIRST (1'b0), .CNT_WIDTH (16)
  ) dut (
    .clk (clk), .rst (rst), .fifo_out (fifo_out), .fifo_out_valid (fifo_out_valid),
    .fifo_out_ack (ack_a), .word_out (word_a), .word_valid (valid_a),
    .word_first (first_a), .word_last (last_a), .word_stall (word_stall),
    .busy (busy_a), .entry_cnt (cnt_a)
`ifdef KME_FIFO_UNPACKER_PARITY_EN
    , .word_par (par_a), .par_err_cnt (perr_a)
`endif
  );

  kme_fifo_unpacker #(
    .IN_WIDTH (IW), .OUT_WIDTH (OW), .MSW_FIRST (1'b1), .CNT_WIDTH (2)
  ) dut_b (
    .clk (clk), .rst (rst), .fifo_out (fifo_out), .fifo_out_valid (fifo_out_valid),
    .fifo_out_ack (ack_b), .word_out (word_b), .word_valid (valid_b),
    .word_first (first_b), .word_last (last_b), .word_stall (word_stall),
    .busy (busy_b), .entry_cnt (cnt_b)
`ifdef KME_FIFO_UNPACKER_PARITY_EN
    , .word_par (par_b), .par_err_cnt (perr_b)
`endif
  );

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_fifo();
    fifo_out_valid = (fifo_q.size() > 0);
    fifo_out       = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_entry(input logic [IW-1:0] e);
    fifo_q.push_back(e);
    for (int i = 0; i < NW; i++) begin
      exp_a.push_back(e[i*OW +: OW]);
      exp_b.push_back(e[(NW-1-i)*OW +: OW]);
    end
    update_fifo();
  endtask

  // Sample point: 4ns after the negedge, 1ns before the next posedge.
  task automatic sample();
    #4;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      sample();
      if (!busy_a && !fifo_out_valid) done = 1'b1;
    end
    chk("wait_idle_timeout", {95'd0, done}, 96'd1);
  endtask

  // Scoreboard monitor: checks every accepted word and pops the FIFO model on ack.
  initial begin : monitor
    int  wpos = 0;
    bit  pop_pending;
    logic [OW-1:0] ea, eb;
    forever begin
      @(negedge clk);
      sample();
      pop_pending = 1'b0;
      if (rst) begin
        wpos = 0;
      end else begin
        chk("ack_ab_match", {95'd0, ack_b}, {95'd0, ack_a});
        if (ack_a) begin
          chk("ack_without_valid", {95'd0, fifo_out_valid}, 96'd1);
          pop_pending = 1'b1;
        end
`ifdef KME_FIFO_UNPACKER_PARITY_EN
        chk("word_par", {95'd0, par_a}, {95'd0, ^word_a});
`endif
        if (valid_a && !word_stall) begin
          if (exp_a.size() == 0) begin
            chk("unexpected_word", {64'd0, word_a}, 96'd0);
          end else begin
            ea = exp_a.pop_front();
            eb = exp_b.pop_front();
            chk("sb_word_lsw", {64'd0, word_a}, {64'd0, ea});
            chk("sb_word_msw", {64'd0, word_b}, {64'd0, eb});
            chk("sb_first", {95'd0, first_a}, {95'd0, wpos == 0});
            chk("sb_last", {95'd0, last_a}, {95'd0, wpos == NW - 1});
            chk("sb_valid_b", {95'd0, valid_b}, 96'd1);
            wpos = (wpos + 1) % NW;
          end
        end
      end
      @(posedge clk);
      #1;
      if (pop_pending && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        update_fifo();
      end
    end
  end

  initial begin : stimulus
    logic [IW-1:0] e1, e2, e3, e4, e5, e6, e7;
    e1 = 96'h33333333_22222222_11111111;
    e2 = 96'hAAAA0003_AAAA0002_AAAA0001;
    e3 = 96'hBBBB0003_BBBB0002_BBBB0001;
    e4 = 96'hCCCC0003_CCCC0002_CCCC0001;
    e5 = 96'hDDDD0003_DDDD0002_DDDD0001;
    e6 = 96'hEEEE0003_EEEE0002_EEEE0001;
    e7 = 96'h77770003_77770002_77770001;
    rst = 1'b1;
    word_stall = 1'b0;
    update_fifo();

    // Reset state
    repeat (2) @(negedge clk);
    sample();
    chk("rst_valid", {95'd0, valid_a}, 96'd0);
    chk("rst_first_last", {94'd0, first_a, last_a}, 96'd0);
    chk("rst_busy", {95'd0, busy_a}, 96'd0);
    chk("rst_word", {64'd0, word_a}, 96'd0);
    chk("rst_ack", {95'd0, ack_a}, 96'd0);
    chk("rst_cnt", {80'd0, cnt_a}, 96'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single entry, no stall
    @(negedge clk);
    push_entry(e1);
    sample();
    chk("t1_ack", {95'd0, ack_a}, 96'd1);
    chk("t1_valid_pre", {95'd0, valid_a}, 96'd0);
    @(negedge clk); sample();
    chk("t1_w0", {64'd0, word_a}, 96'h11111111);
    chk("t1_w0_msw", {64'd0, word_b}, 96'h33333333);
    chk("t1_w0_first", {94'd0, first_a, last_a}, 96'b10);
    chk("t1_w0_noack", {95'd0, ack_a}, 96'd0);
    @(negedge clk); sample();
    chk("t1_w1", {64'd0, word_a}, 96'h22222222);
    @(negedge clk); sample();
    chk("t1_w2", {64'd0, word_a}, 96'h33333333);
    chk("t1_w2_last", {94'd0, first_a, last_a}, 96'b01);
    chk("t1_w2_msw", {64'd0, word_b}, 96'h11111111);
    @(negedge clk); sample();
    chk("t1_idle", {95'd0, busy_a}, 96'd0);
    chk("t1_cnt", {80'd0, cnt_a}, 96'd1);

    // Two queued entries, zero bubble
    @(negedge clk);
    push_entry(e2);
    push_entry(e3);
    sample();
    chk("t2_ack0", {95'd0, ack_a}, 96'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); sample();
      chk("t2_valid", {95'd0, valid_a}, 96'd1);
      chk("t2_ack", {95'd0, ack_a}, {95'd0, k == 2});
    end
    @(negedge clk); sample();
    chk("t2_idle", {95'd0, valid_a}, 96'd0);
    chk("t2_cnt", {80'd0, cnt_a}, 96'd3);

    // Stall on word 1 for three cycles
    @(negedge clk);
    push_entry(e4);
    sample();
    @(negedge clk); sample();
    chk("t3_w0", {64'd0, word_a}, {64'd0, e4[31:0]});
    @(negedge clk);
    word_stall = 1'b1;
    sample();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(negedge clk); sample();
      end
      chk("t3_hold_word", {64'd0, word_a}, {64'd0, e4[63:32]});
      chk("t3_hold_valid", {95'd0, valid_a}, 96'd1);
      chk("t3_hold_flags", {94'd0, first_a, last_a}, 96'b00);
      chk("t3_hold_ack", {95'd0, ack_a}, 96'd0);
    end
    @(negedge clk);
    word_stall = 1'b0;
    sample();
    chk("t3_resume", {64'd0, word_a}, {64'd0, e4[63:32]});
    @(negedge clk); sample();
    chk("t3_w2", {64'd0, word_a}, {64'd0, e4[95:64]});
    @(negedge clk); sample();
    chk("t3_cnt", {80'd0, cnt_a}, 96'd4);

    // Stall on last word with the FIFO non-empty
    @(negedge clk);
    push_entry(e5);
    sample();
    @(negedge clk); sample();
    @(negedge clk); sample();
    @(negedge clk);
    word_stall = 1'b1;
    push_entry(e6);
    sample();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(negedge clk); sample();
      end
      chk("t4_stall_last", {95'd0, last_a}, 96'd1);
      chk("t4_stall_noack", {95'd0, ack_a}, 96'd0);
    end
    @(negedge clk);
    word_stall = 1'b0;
    sample();
    chk("t4_release_ack", {95'd0, ack_a}, 96'd1);
    chk("t4_release_last", {95'd0, last_a}, 96'd1);
    @(negedge clk); sample();
    chk("t4_reload_w0", {64'd0, word_a}, {64'd0, e6[31:0]});
    chk("t4_reload_first", {95'd0, first_a}, 96'd1);
    wait_idle(10);
    chk("t4_cnt", {80'd0, cnt_a}, 96'd6);

    // Reset mid-entry at idx 1
    @(negedge clk);
    push_entry(e7);
    sample();
    @(negedge clk); sample();
    @(negedge clk);
    rst = 1'b1;
    sample();
    @(negedge clk);
    rst = 1'b0;
    exp_a.delete();
    exp_b.delete();
    sample();
    chk("t5_valid", {95'd0, valid_a}, 96'd0);
    chk("t5_busy", {95'd0, busy_a}, 96'd0);
    chk("t5_cnt", {80'd0, cnt_a}, 96'd0);
    chk("t5_cnt_b", {94'd0, cnt_b}, 96'd0);
    @(negedge clk);
    push_entry(e1);
    sample();
    @(negedge clk); sample();
    chk("t5_restart_w0", {64'd0, word_a}, 96'h11111111);
    chk("t5_restart_first", {95'd0, first_a}, 96'd1);
    wait_idle(10);
    chk("t5_cnt_after", {80'd0, cnt_a}, 96'd1);

    // Saturation of the 2-bit counter
    @(negedge clk);
    push_entry(e2);
    push_entry(e3);
    wait_idle(20);
    chk("t6_sat", {94'd0, cnt_b}, 96'd3);
    chk("t6_cnt_a", {80'd0, cnt_a}, 96'd3);
    @(negedge clk);
    push_entry(e4);
    wait_idle(10);
    chk("t6_sat_hold", {94'd0, cnt_b}, 96'd3);
    chk("t6_cnt_a2", {80'd0, cnt_a}, 96'd4);

    chk("sb_drained", {64'd0, 32'(exp_a.size())}, 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
